// File: rtl/thunderbird_seq_pkg.sv
// -----------------------------------------------------------------------------
// thunderbird_pkg
// Shared types and helpers for the Thunderbird tail-light sequencer.
//   mode_t : sequencer mode (IDLE, LEFT, RIGHT, HAZ), 2 bits
//   therm(): thermometer code, bit i set when i < k, limited to 'width' bits
// -----------------------------------------------------------------------------
package thunderbird_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        HAZ   = 2'd3
    } mode_t;

    // Widest lamp bank the thermometer helper can produce.
    localparam int THERM_MAX = 32;

    // Thermometer code: the k lowest bits set, never more than 'width' bits.
    // Callers slice the result down to their own lamp count.
    function automatic logic [THERM_MAX-1:0] therm(input int unsigned k,
                                                   input int unsigned width);
        logic [THERM_MAX-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < THERM_MAX; i++) begin
            if ((i < k) && (i < width)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/thunderbird_seq_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Step-rate prescaler. A counter runs 0..PRESCALE-1 and wraps; tick is high
// while the counter sits at its last value. With PRESCALE=1 tick is constant 1.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset (counter back to 0)
//   tick  : one-cycle step enable
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    generate
        if (PRESCALE <= 1) begin : g_bypass
            // Every clock is a step; clock and reset are not needed here.
            logic w_unused_ok;
            assign w_unused_ok = &{1'b0, clk, reset};
            assign tick        = 1'b1;
        end else begin : g_count
            localparam int             CW   = $clog2(PRESCALE);
            localparam logic [CW-1:0]  LAST = CW'(PRESCALE - 1);

            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_cnt <= '0;
                end else if (r_cnt == LAST) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign tick = (r_cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/thunderbird_seq.sv
// -----------------------------------------------------------------------------
// thunderbird_seq
// Parametrised Thunderbird tail-light sequencer: sequential turn sweep per
// side, hazard flashing and brake overlay, stepping at the tick_gen rate.
// Parameters:
//   LAMPS    : lamps per side (>=1), bit 0 innermost
//   PRESCALE : clk cycles per sequence step (>=1)
// Ports:
//   clk     : system clock, rising edge
//   reset   : asynchronous, active-low reset
//   left    : left turn request
//   right   : right turn request
//   hazard  : hazard request
//   brake   : brake pedal
//   lamp_l  : left lamps, bit i = lamp i (registered)
//   lamp_r  : right lamps (registered)
//   active  : high while mode != IDLE (registered)
// -----------------------------------------------------------------------------
module thunderbird_seq
    import thunderbird_pkg::*;
#(
    parameter int LAMPS    = 3,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
    input  logic             brake,
    output logic [LAMPS-1:0] lamp_l,
    output logic [LAMPS-1:0] lamp_r,
    output logic             active
);

    localparam int            SW        = $clog2(LAMPS + 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(LAMPS);

    logic             w_tick;
    logic             w_haz_req;
    logic             w_enter;
    mode_t            r_mode;
    mode_t            w_mode_next;
    logic [SW-1:0]    r_step;
    logic [SW-1:0]    w_step_next;
    logic [LAMPS-1:0] r_lamp_l;
    logic [LAMPS-1:0] r_lamp_r;
    logic             r_active;
    logic [LAMPS-1:0] w_lamp_l_next;
    logic [LAMPS-1:0] w_lamp_r_next;
    logic [THERM_MAX-1:0] w_therm_full;
    logic [LAMPS-1:0] w_sweep;
    logic [LAMPS-1:0] w_brake_fill;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    // Both turn requests together are treated exactly like hazard.
    assign w_haz_req = hazard | (left & right);

    // IDLE and the dark half of a hazard flash share the same entry rules.
    assign w_enter = (r_mode == IDLE) || ((r_mode == HAZ) && (r_step == '0));

    // ---------------- next-state logic ----------------
    always_comb begin
        w_mode_next = r_mode;
        w_step_next = r_step;
        if (w_tick) begin
            if (w_enter) begin
                if (w_haz_req) begin
                    w_mode_next = HAZ;
                    w_step_next = SW'(1);
                end else if (left) begin
                    w_mode_next = LEFT;
                    w_step_next = SW'(1);
                end else if (right) begin
                    w_mode_next = RIGHT;
                    w_step_next = SW'(1);
                end else begin
                    w_mode_next = IDLE;
                    w_step_next = '0;
                end
            end else if (r_mode == HAZ) begin
                // Lit half of the flash: go dark, new hazard requests ignored.
                w_step_next = '0;
            end else if (w_haz_req) begin
                // Hazard aborts a running sweep.
                w_mode_next = HAZ;
                w_step_next = SW'(1);
            end else if (r_step < LAST_STEP) begin
                w_step_next = r_step + 1'b1;
            end else begin
                // Sweep finished; a held request re-enters after one dark step.
                w_mode_next = IDLE;
                w_step_next = '0;
            end
        end
    end

    // ---------------- lamp decode ----------------
    // Decoded from the next state and the live brake input so the registered
    // lamps change on the same edge as the state, and brake shows one clk late.
    assign w_therm_full = therm(32'(w_step_next), LAMPS);
    assign w_sweep      = w_therm_full[LAMPS-1:0];
    assign w_brake_fill = {LAMPS{brake}};

    always_comb begin
        w_lamp_l_next = '0;
        w_lamp_r_next = '0;
        case (w_mode_next)
            IDLE: begin
                w_lamp_l_next = w_brake_fill;
                w_lamp_r_next = w_brake_fill;
            end
            LEFT: begin
                w_lamp_l_next = w_sweep;
                w_lamp_r_next = w_brake_fill;
            end
            RIGHT: begin
                w_lamp_l_next = w_brake_fill;
                w_lamp_r_next = w_sweep;
            end
            HAZ: begin
                // Brake deliberately has no effect while flashing.
                w_lamp_l_next = {LAMPS{w_step_next[0]}};
                w_lamp_r_next = {LAMPS{w_step_next[0]}};
            end
            default: begin
                w_lamp_l_next = '0;
                w_lamp_r_next = '0;
            end
        endcase
    end

    // ---------------- state and output registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode   <= IDLE;
            r_step   <= '0;
            r_lamp_l <= '0;
            r_lamp_r <= '0;
            r_active <= 1'b0;
        end else begin
            r_mode   <= w_mode_next;
            r_step   <= w_step_next;
            r_lamp_l <= w_lamp_l_next;
            r_lamp_r <= w_lamp_r_next;
            r_active <= (w_mode_next != IDLE);
        end
    end

    assign lamp_l = r_lamp_l;
    assign lamp_r = r_lamp_r;
    assign active = r_active;

endmodule

// File: doc/thunderbird_seq.md
Name: thunderbird_seq

Overview:
Parametrised Thunderbird-style tail-light sequencer, successor to the fixed 3-lamp turn-signal FSM. It drives LAMPS lamps per side with sequential turn indication, plus hazard and brake modes. A built-in prescaler sets the step rate. It sits between the board wrapper (switches/key clock) and the LED outputs.

Parameters:
LAMPS, 3, lamps per side (>=1); bit 0 is the innermost lamp.
PRESCALE, 1, clk cycles per sequence step (>=1); 1 gives one step per clk.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
left  input  1  left turn request
right  input  1  right turn request
hazard  input  1  hazard request
brake  input  1  brake pedal
lamp_l  output  LAMPS  left lamps, bit i = lamp i
lamp_r  output  LAMPS  right lamps
active  output  1  high when mode != IDLE

Behaviour:
- Reset (reset=0, async): mode=IDLE, step=0, prescale cnt=0, brake_q=0, lamp_l=0, lamp_r=0, active=0.
- Prescaler: cnt runs 0..PRESCALE-1 and wraps. tick = (cnt==PRESCALE-1). With PRESCALE=1, tick is constant 1.
- State: mode in {IDLE, LEFT, RIGHT, HAZ}; step is 0..LAMPS, width $clog2(LAMPS+1).
- Requests are sampled only on tick. Define haz_req = hazard | (left & right).
- Transitions, on tick only:
  - IDLE:
    - haz_req -> HAZ, step=1.
    - else left -> LEFT, step=1.
    - else right -> RIGHT, step=1.
    - else stay.
  - LEFT/RIGHT:
    - haz_req -> HAZ, step=1 (aborts the sequence).
    - else step<LAMPS -> step+1.
    - else (step==LAMPS) -> IDLE, step=0.
  - Releasing left/right mid-sequence does not abort; the sequence runs to completion.
  - Holding a request re-enters the sequence on the tick after IDLE, giving one all-off step between sweeps.
  - HAZ:
    - step==1 -> step=0, stay HAZ.
    - step==0 -> apply the IDLE rules: haz_req gives step=1, a single side request enters that side's sequence, no request gives IDLE.
- Lamp decode (therm(k)[i] = i<k):
  - LEFT: lamp_l=therm(step), lamp_r=0.
  - RIGHT: mirror of LEFT.
  - HAZ: both sides = {LAMPS{step[0]}}.
  - IDLE: both sides 0.
- Brake overlay: brake_q is brake registered every clk, not gated by tick.
  - In IDLE, LEFT or RIGHT, any side not sequencing is forced all-ones while brake_q=1.
  - In HAZ, brake has no effect.
- Outputs are registered. They reflect the state and brake_q as they stand after the same clock edge, so a state change on a tick edge and the matching lamp change appear together. Brake has 1 clk latency.
- active = (mode != IDLE), registered with the state.
- Simultaneous left & right without hazard is treated as hazard.
- A hazard request during HAZ step 1 is a no-op.
- Reset assertion mid-sequence clears everything immediately. After release, operation resumes from IDLE with cnt=0.

Decomposition:
- Package thunderbird_pkg holds:
  - mode_t enum {IDLE, LEFT, RIGHT, HAZ}, 2 bits;
  - a therm() function parametrised by width.
- Sub-module tick_gen(clk, reset, tick) with parameter PRESCALE is the prescaler.
- FSM and lamp decode live in thunderbird_seq.

Test Plan:
1. LAMPS=3, PRESCALE=1; reset, then hold left=1 -> lamp_l per clk 001,011,111,000,001,...; lamp_r=000; active low only on the 000 steps.
2. Left high for one cycle, then low -> lamp_l 001,011,111,000, then stays 000; active=0 after the sweep.
3. Left=right=1 -> both sides 111,000,111,000; release both during an on step -> one more 000 step, then IDLE.
4. Right sweep at lamp_r=011; assert hazard for one cycle -> next clk both sides 111, then 000, then IDLE (hazard gone).
5. Brake=1 with right held -> lamp_l=111 (one clk after brake rises), lamp_r sweeps; brake alone -> both 111; brake during HAZ -> pattern unchanged.
6. LAMPS=5, PRESCALE=4; hold left -> lamp_l steps 00001,00011,... every 4 clks; assert reset=0 at step 3 -> lamps 00000 and active=0 immediately, without waiting for a clk edge.
